// File: rtl/alu_issue_unit.sv
// ALU issue sequencer: fetches operands from an 8x16 register file, drives
// the external combinational ALU, then writes the result back with Z/N flags.
module alu_issue_unit #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   input  logic              host_we,
   input  logic [2:0]        host_waddr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [2:0]        host_raddr,
   output logic [DATA_W-1:0] host_rdata,
   output logic [2:0]        alu_mode,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              flag_z,
   output logic              flag_n,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   logic [2:0]        mode_q, mode_d;
   logic [DATA_W-1:0] in1_q, in1_d;
   logic [DATA_W-1:0] in2_q, in2_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [2:0]        rd_q, rd_d;
   logic              z_q, z_d;
   logic              n_q, n_d;

   logic [2:0]        rs1, rs2;
   logic [DATA_W-1:0] rs1_val, rs2_val, imm_val;

   assign rs1     = instr[8:6];
   assign rs2     = instr[2:0];
   assign rs1_val = (rs1 == 3'd0) ? '0 : regs_q[rs1];
   assign rs2_val = (rs2 == 3'd0) ? '0 : regs_q[rs2];
   assign imm_val = {{(DATA_W-6){1'b0}}, instr[5:0]};

   assign host_rdata  = (host_raddr == 3'd0) ? '0 : regs_q[host_raddr];
   assign instr_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == WB);
   assign alu_mode    = mode_q;
   assign alu_in1     = in1_q;
   assign alu_in2     = in2_q;
   assign result      = res_q;
   assign flag_z      = z_q;
   assign flag_n      = n_q;

   always_comb begin
      state_d = state_q;
      regs_d  = regs_q;
      mode_d  = mode_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      res_d   = res_q;
      rd_d    = rd_q;
      z_d     = z_q;
      n_d     = n_q;
      unique case (state_q)
         IDLE: begin
            // operands are taken from rs*_val (pre-write) even on a same-edge host write
            if (host_we && host_waddr != 3'd0)
               regs_d[host_waddr] = host_wdata;
            if (instr_valid) begin
               state_d = EXEC;
               mode_d  = instr[14:12];
               in1_d   = rs1_val;
               in2_d   = instr[15] ? imm_val : rs2_val;
               rd_d    = instr[11:9];
            end
         end
         EXEC: begin
            state_d = WB;
            res_d   = alu_result;
            z_d     = (alu_result == '0);
            n_d     = alu_result[DATA_W-1];
            if (rd_q != 3'd0)
               regs_d[rd_q] = alu_result;
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         mode_q <= '0;
         in1_q  <= '0;
         in2_q  <= '0;
         res_q  <= '0;
         rd_q   <= '0;
         z_q    <= 1'b0;
         n_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         mode_q  <= mode_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU and a
// register-file reference model driven by directed and $urandom stimulus.
module tb_alu_issue_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic        host_we = 1'b0;
   logic [2:0]  host_waddr = '0;
   logic [15:0] host_wdata = '0;
   logic [2:0]  host_raddr = '0;
   logic [15:0] host_rdata;
   logic [2:0]  alu_mode;
   logic [15:0] alu_in1, alu_in2, alu_result, result;
   logic        done, flag_z, flag_n, busy;

   int checks = 0;
   int errors = 0;
   logic [15:0] mregs [8];

   always #5 clk = ~clk;

   // Behavioural stand-in for the team ALU
   function automatic logic [15:0] alu_fn(input logic [2:0] m,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      case (m)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a >> b[3:0];
         3'd3:    return a << b[3:0];
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return ~a;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_mode, alu_in1, alu_in2);

   alu_issue_unit dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
      .host_raddr(host_raddr), .host_rdata(host_rdata),
      .alu_mode(alu_mode), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .result(result), .done(done),
      .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
   );

   typedef struct packed {
      logic [2:0]  mode;
      logic [15:0] in1;
      logic [15:0] in2;
      logic        rdy_e;
      logic        done_e;
      logic        done_w;
      logic [15:0] res;
      logic        z;
      logic        n;
      logic [15:0] rdd;
      logic        rdy_w;
      logic        done_a;
      logic        rdy_a;
   } obs_t;

   function automatic logic [15:0] mk(input logic imm, input logic [2:0] op,
                                      input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [5:0] lo);
      return {imm, op, rd, rs1, lo};
   endfunction

   function automatic logic [15:0] rdv(input logic [2:0] a);
      return (a == 3'd0) ? 16'h0 : mregs[a];
   endfunction

   function automatic logic [15:0] op2(input logic [15:0] ins);
      return ins[15] ? {10'b0, ins[5:0]} : rdv(ins[2:0]);
   endfunction

   function automatic logic [15:0] exp_res(input logic [15:0] ins);
      return alu_fn(ins[14:12], rdv(ins[8:6]), op2(ins));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [15:0] d);
      host_we = 1'b1; host_waddr = a; host_wdata = d;
      step();
      host_we = 1'b0;
      if (a != 3'd0) mregs[a] = d;
   endtask

   // Drives one instruction from IDLE and captures what is seen in EXEC, WB, after
   task automatic exec_instr(input logic [15:0] ins, output obs_t o);
      host_raddr = ins[11:9];
      instr = ins; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0; instr = 16'($urandom);
      o.mode = alu_mode; o.in1 = alu_in1; o.in2 = alu_in2;
      o.rdy_e = instr_ready; o.done_e = done;
      step();
      o.done_w = done; o.res = result; o.z = flag_z; o.n = flag_n;
      o.rdd = host_rdata; o.rdy_w = instr_ready;
      step();
      o.done_a = done; o.rdy_a = instr_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({alu_mode, alu_in1, alu_in2, result, flag_z, flag_n, done, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outs: got mode=%0d in1=%h in2=%h res=%h z=%b n=%b done=%b busy=%b want all 0",
                  alu_mode, alu_in1, alu_in2, result, flag_z, flag_n, done, busy);
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", instr_ready);
      end
      for (int i = 0; i < 8; i++) begin
         mregs[i] = '0;
         host_raddr = 3'(i); #1;
         checks++;
         if (host_rdata !== 16'h0) begin
            errors++; $display("FAIL reset_r%0d: got %h want 0000", i, host_rdata);
         end
      end
      host_write(3'd1, 16'd200);
      host_write(3'd2, 16'd300);
      host_raddr = 3'd1; #1;
      checks++;
      if (host_rdata !== 16'd200) begin
         errors++; $display("FAIL preload_r1: got %0d want 200", host_rdata);
      end
      host_raddr = 3'd2; #1;
      checks++;
      if (host_rdata !== 16'd300) begin
         errors++; $display("FAIL preload_r2: got %0d want 300", host_rdata);
      end
   endtask

   task automatic test_add();
      obs_t o;
      exec_instr(mk(1'b0, 3'd0, 3'd3, 3'd1, 6'd2), o);
      mregs[3] = 16'd500;
      checks++;
      if ({o.mode, o.in1, o.in2} !== {3'd0, 16'd200, 16'd300}) begin
         errors++; $display("FAIL add_operands: got mode=%0d in1=%0d in2=%0d want 0/200/300",
                             o.mode, o.in1, o.in2);
      end
      checks++;
      if ({o.rdy_e, o.done_e} !== 2'b00) begin
         errors++; $display("FAIL add_exec_hs: got ready=%b done=%b want 0 0", o.rdy_e, o.done_e);
      end
      checks++;
      if ({o.done_w, o.res, o.rdd, o.z, o.n, o.rdy_w} !== {1'b1, 16'd500, 16'd500, 3'b000}) begin
         errors++; $display("FAIL add_wb: got done=%b res=%0d r3=%0d z=%b n=%b ready=%b want 1 500 500 0 0 0",
                             o.done_w, o.res, o.rdd, o.z, o.n, o.rdy_w);
      end
      checks++;
      if ({o.done_a, o.rdy_a} !== 2'b01) begin
         errors++; $display("FAIL add_idle: got done=%b ready=%b want 0 1", o.done_a, o.rdy_a);
      end
   endtask

   task automatic test_sub_flags();
      obs_t o;
      exec_instr(mk(1'b0, 3'd1, 3'd4, 3'd1, 6'd2), o);
      mregs[4] = 16'hFF9C;
      checks++;
      if ({o.res, o.z, o.n} !== {16'hFF9C, 2'b01}) begin
         errors++; $display("FAIL sub_neg: got res=%h z=%b n=%b want FF9C 0 1", o.res, o.z, o.n);
      end
      exec_instr(mk(1'b0, 3'd1, 3'd6, 3'd1, 6'd1), o);
      mregs[6] = 16'h0;
      checks++;
      if ({o.res, o.z, o.n} !== {16'h0, 2'b10}) begin
         errors++; $display("FAIL sub_zero: got res=%h z=%b n=%b want 0000 1 0", o.res, o.z, o.n);
      end
   endtask

   task automatic test_imm_rd0();
      obs_t o;
      exec_instr(mk(1'b1, 3'd7, 3'd0, 3'd1, 6'h3F), o);
      checks++;
      if ({o.mode, o.in2} !== {3'd7, 16'h003F}) begin
         errors++; $display("FAIL imm_operand: got mode=%0d in2=%h want 7 003F", o.mode, o.in2);
      end
      checks++;
      if ({o.done_w, o.res} !== {1'b1, 16'h00F7}) begin
         errors++; $display("FAIL imm_result: got done=%b res=%h want 1 00F7", o.done_w, o.res);
      end
      host_raddr = 3'd0; #1;
      checks++;
      if (host_rdata !== 16'h0) begin
         errors++; $display("FAIL r0_zero: got %h want 0000", host_rdata);
      end
   endtask

   task automatic test_busy();
      logic [15:0] pend, ins, wd;
      logic [2:0]  prd;
      logic [2:0]  v;
      pend = '0; prd = '0;
      instr_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         ins = 16'($urandom);
         instr = ins;
         if (k % 3 == 0) begin
            pend = exp_res(ins);
            prd  = ins[11:9];
         end
         step();
         if (k % 3 == 1 && prd != 3'd0) mregs[prd] = pend;
         v = {done, instr_ready, busy};
         checks++;
         if (v !== ((k % 3 == 1) ? 3'b101 : (k % 3 == 2) ? 3'b010 : 3'b001)) begin
            errors++; $display("FAIL busy_seq k=%0d: got done/ready/busy=%b", k, v);
         end
         if (k % 3 == 1) begin
            checks++;
            if (result !== pend) begin
               errors++; $display("FAIL busy_res k=%0d: got %h want %h", k, result, pend);
            end
         end
      end
      instr_valid = 1'b0;
      ins = mk(1'b0, 3'd0, 3'd3, 3'd1, 6'd2);
      pend = exp_res(ins);
      wd = ~mregs[6];
      instr = ins; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      host_we = 1'b1; host_waddr = 3'd6; host_wdata = wd;
      step();
      step();
      host_we = 1'b0;
      mregs[3] = pend;
      host_raddr = 3'd6; #1;
      checks++;
      if (host_rdata !== mregs[6]) begin
         errors++; $display("FAIL busy_hostwr: got %h want %h", host_rdata, mregs[6]);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      instr = mk(1'b0, 3'd0, 3'd5, 3'd1, 6'd2); instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({done, busy, result, alu_in1} !== '0) begin
         errors++; $display("FAIL rstmid_async: got done=%b busy=%b res=%h in1=%h want 0",
                             done, busy, result, alu_in1);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (done === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen != 0 || instr_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_done: got %0d done pulses ready=%b want 0 1", seen, instr_ready);
      end
      host_raddr = 3'd5; #1;
      checks++;
      if (host_rdata !== 16'h0) begin
         errors++; $display("FAIL rstmid_r5: got %h want 0000", host_rdata);
      end
   endtask

   task automatic test_same_edge();
      host_write(3'd1, 16'd200);
      host_write(3'd2, 16'd300);
      host_we = 1'b1; host_waddr = 3'd1; host_wdata = 16'd7;
      instr = mk(1'b0, 3'd0, 3'd5, 3'd1, 6'd2); instr_valid = 1'b1;
      step();
      host_we = 1'b0; instr_valid = 1'b0;
      checks++;
      if (alu_in1 !== 16'd200) begin
         errors++; $display("FAIL same_in1: got %0d want 200", alu_in1);
      end
      step();
      checks++;
      if ({done, result} !== {1'b1, 16'd500}) begin
         errors++; $display("FAIL same_res: got done=%b res=%0d want 1 500", done, result);
      end
      step();
      mregs[1] = 16'd7; mregs[5] = 16'd500;
      host_raddr = 3'd5; #1;
      checks++;
      if (host_rdata !== 16'd500) begin
         errors++; $display("FAIL same_r5: got %0d want 500", host_rdata);
      end
      host_raddr = 3'd1; #1;
      checks++;
      if (host_rdata !== 16'd7) begin
         errors++; $display("FAIL same_r1: got %0d want 7", host_rdata);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [15:0] ins, er, ea, eb;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1)
            host_write(3'($urandom_range(0, 7)), 16'($urandom));
         ins = 16'($urandom);
         ea = rdv(ins[8:6]); eb = op2(ins); er = exp_res(ins);
         exec_instr(ins, o);
         if (ins[11:9] != 3'd0) mregs[ins[11:9]] = er;
         checks++;
         if ({o.mode, o.in1, o.in2} !== {ins[14:12], ea, eb}) begin
            errors++; $display("FAIL rand_ops t=%0d: got %0d %h %h want %0d %h %h",
                                t, o.mode, o.in1, o.in2, ins[14:12], ea, eb);
         end
         checks++;
         if ({o.done_w, o.res, o.z, o.n, o.rdd, o.rdy_a} !==
             {1'b1, er, er == 16'h0, er[15], rdv(ins[11:9]), 1'b1}) begin
            errors++; $display("FAIL rand_wb t=%0d: got done=%b res=%h z=%b n=%b rd=%h want %h",
                                t, o.done_w, o.res, o.z, o.n, o.rdd, er);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_sub_flags();
      test_imm_rd0();
      test_busy();
      test_reset_mid();
      test_same_edge();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
